// File: rtl/aes_byte_sequencer.sv
// Byte-serial bridge between the 128-bit register controller and the 8-bit AES core:
// streams key/plaintext into the core, then reassembles the 16 result bytes.
module aes_byte_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int NBYTES         = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         aes_start,
  input  logic [127:0] key_block,
  input  logic [127:0] pt_block,
  output logic [127:0] ct_block,
  output logic         aes_busy,
  output logic         aes_done,
  output logic         aes_err,
  output logic         core_ld,
  output logic [7:0]   core_key_byte,
  output logic [7:0]   core_pt_byte,
  input  logic         core_done,
  input  logic         core_dvld,
  input  logic [7:0]   core_dout
);

  localparam int             TW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [3:0]     LAST    = 4'(NBYTES - 1);
  localparam logic [TW-1:0]  TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WAIT    = 3'd2,
    COLLECT = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [TW-1:0]   to_cnt_q;
  // Byte 0 leaves straight from the input bus; only bytes 1..15 need holding.
  logic [119:0]    key_sh_q;
  logic [119:0]    pt_sh_q;
  logic [119:0]    asm_q;
  logic [127:0]    ct_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            ld_q;
  logic [7:0]      kb_q;
  logic [7:0]      pb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      to_cnt_q <= '0;
      key_sh_q <= '0;
      pt_sh_q  <= '0;
      asm_q    <= '0;
      ct_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ld_q     <= 1'b0;
      kb_q     <= '0;
      pb_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (aes_start) begin
            state_q  <= LOAD;
            busy_q   <= 1'b1;
            ld_q     <= 1'b1;
            cnt_q    <= '0;
            kb_q     <= key_block[127:120];
            pb_q     <= pt_block[127:120];
            key_sh_q <= key_block[119:0];
            pt_sh_q  <= pt_block[119:0];
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          if (cnt_q == LAST) begin
            state_q  <= WAIT;
            ld_q     <= 1'b0;
            to_cnt_q <= '0;
          end else begin
            cnt_q    <= cnt_q + 4'd1;
            kb_q     <= key_sh_q[119:112];
            pb_q     <= pt_sh_q[119:112];
            key_sh_q <= {key_sh_q[111:0], 8'h00};
            pt_sh_q  <= {pt_sh_q[111:0], 8'h00};
          end
        end
        WAIT: begin
          if (core_done) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
          end else if ((TIMEOUT_CYCLES > 0) && (to_cnt_q == TO_LAST)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        COLLECT: begin
          if (core_dvld) begin
            asm_q <= {asm_q[111:0], core_dout};
            if (cnt_q == LAST) begin
              ct_q    <= {asm_q, core_dout};
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ct_block      = ct_q;
  assign aes_busy      = busy_q;
  assign aes_done      = done_q;
  assign aes_err       = err_q;
  assign core_ld       = ld_q;
  assign core_key_byte = kb_q;
  assign core_pt_byte  = pb_q;

endmodule

// File: tb/tb_aes_byte_sequencer.sv
// Bench for aes_byte_sequencer: a bench-side core model feeds result bytes, and
// expectations come from byte-indexing the blocks with plain shifts.
module tb_aes_byte_sequencer;

  logic         clk;
  logic         rst_n;
  logic         aes_start;
  logic [127:0] key_block;
  logic [127:0] pt_block;
  logic [127:0] ct_block;
  logic         aes_busy, aes_done, aes_err, core_ld;
  logic [7:0]   core_key_byte, core_pt_byte;
  logic         core_done, core_dvld;
  logic [7:0]   core_dout;

  logic         t_start;
  logic [127:0] t_ct;
  logic         t_busy, t_done, t_err, t_ld;
  logic [7:0]   t_kb, t_pb;
  logic         t_core_done, t_core_dvld;
  logic [7:0]   t_core_dout;

  int errors = 0;
  int checks = 0;
  logic [127:0] last_ct;

  aes_byte_sequencer dut (
    .clk(clk), .rst_n(rst_n), .aes_start(aes_start),
    .key_block(key_block), .pt_block(pt_block), .ct_block(ct_block),
    .aes_busy(aes_busy), .aes_done(aes_done), .aes_err(aes_err),
    .core_ld(core_ld), .core_key_byte(core_key_byte), .core_pt_byte(core_pt_byte),
    .core_done(core_done), .core_dvld(core_dvld), .core_dout(core_dout)
  );

  aes_byte_sequencer #(.TIMEOUT_CYCLES(8)) dut_t (
    .clk(clk), .rst_n(rst_n), .aes_start(t_start),
    .key_block(key_block), .pt_block(pt_block), .ct_block(t_ct),
    .aes_busy(t_busy), .aes_done(t_done), .aes_err(t_err),
    .core_ld(t_ld), .core_key_byte(t_kb), .core_pt_byte(t_pb),
    .core_done(t_core_done), .core_dvld(t_core_dvld), .core_dout(t_core_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte i of a block in FIPS-197 order: byte 0 is the most significant.
  function automatic logic [7:0] byte_of(input logic [127:0] b, input int i);
    return 8'((b >> (8 * (15 - i))) & 128'hff);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full transaction on the main DUT. pre: start already accepted (we are in
  // LOAD byte 0). hold: keep aes_start high and present nk/np in the DONE cycle.
  // abort_at >= 0: pull reset after that many result bytes.
  task automatic run_block(input logic [127:0] k, input logic [127:0] p,
                           input logic [127:0] r, input int wlen, input int gmode,
                           input int chg_at, input bit hold, input bit pre,
                           input logic [127:0] nk, input logic [127:0] np,
                           input int abort_at);
    int  b;
    int  cyc;
    bit  tog;
    bit  dv;
    logic [127:0] exp_ct;
    if (!pre) begin
      @(negedge clk);
      key_block = k;
      pt_block  = p;
      aes_start = 1'b1;
      @(negedge clk);
    end
    if (!hold) aes_start = 1'b0;
    chk("done_low_at_load", 128'(aes_done), 128'd0);
    for (int i = 0; i < 16; i++) begin
      chk("core_ld", 128'(core_ld), 128'd1);
      chk("key_byte", 128'(core_key_byte), 128'(byte_of(k, i)));
      chk("pt_byte", 128'(core_pt_byte), 128'(byte_of(p, i)));
      chk("busy_load", 128'(aes_busy), 128'd1);
      if (i == chg_at) begin
        key_block = rnd128();
        pt_block  = rnd128();
      end
      core_done = 1'($urandom % 2);
      core_dvld = 1'($urandom % 2);
      core_dout = 8'($urandom);
      @(negedge clk);
    end
    chk("ld_off_wait", 128'(core_ld), 128'd0);
    chk("busy_wait", 128'(aes_busy), 128'd1);
    for (int w = 1; w < wlen; w++) begin
      core_done = 1'b0;
      core_dvld = 1'b1;
      core_dout = 8'($urandom);
      @(negedge clk);
    end
    core_done = 1'b1;
    core_dvld = 1'b1;
    core_dout = 8'($urandom);
    @(negedge clk);
    exp_ct = '0;
    for (int i = 0; i < 16; i++) exp_ct = (exp_ct << 8) | 128'(byte_of(r, i));
    b   = 0;
    cyc = 0;
    tog = 1'b1;
    while (b < 16) begin
      if (abort_at >= 0 && b == abort_at) begin
        core_dvld = 1'b0;
        core_done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ct", ct_block, 128'd0);
        chk("rst_busy", 128'(aes_busy), 128'd0);
        chk("rst_ld", 128'(core_ld), 128'd0);
        chk("rst_bytes", 128'({core_key_byte, core_pt_byte}), 128'd0);
        chk("rst_flags", 128'({aes_done, aes_err}), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_quiet", 128'({aes_busy, aes_done, aes_err}), 128'd0);
        last_ct = '0;
        return;
      end
      if (gmode == 0 || cyc > 64) dv = 1'b1;
      else if (gmode == 1)        dv = tog;
      else                        dv = ($urandom % 3) != 0;
      tog = ~tog;
      core_dvld = dv;
      core_dout = dv ? byte_of(r, b) : 8'($urandom);
      core_done = 1'($urandom % 2);
      @(negedge clk);
      if (dv) b++;
      cyc++;
      if (b < 16) chk("done_early", 128'(aes_done), 128'd0);
    end
    core_dvld = 1'b0;
    core_done = 1'b0;
    chk("done_pulse", 128'(aes_done), 128'd1);
    chk("ct_block", ct_block, exp_ct);
    chk("busy_done", 128'(aes_busy), 128'd0);
    last_ct = exp_ct;
    if (hold) begin
      key_block = nk;
      pt_block  = np;
    end else begin
      @(negedge clk);
      chk("done_one_cycle", 128'(aes_done), 128'd0);
      chk("ct_hold", ct_block, last_ct);
      chk("busy_idle", 128'(aes_busy), 128'd0);
    end
  endtask

  initial begin
    logic [127:0] k0, p0, r0, k1, p1, r1;
    rst_n = 1'b1;
    aes_start = 1'b0;
    key_block = '0;
    pt_block = '0;
    core_done = 1'b0;
    core_dvld = 1'b0;
    core_dout = '0;
    t_start = 1'b0;
    t_core_done = 1'b0;
    t_core_dvld = 1'b0;
    t_core_dout = '0;
    last_ct = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ct", ct_block, 128'd0);
    chk("reset_status", 128'({aes_busy, aes_done, aes_err}), 128'd0);
    chk("reset_core_if", 128'({core_ld, core_key_byte, core_pt_byte}), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known FIPS-197 vector
    run_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 20, 0, -1, 1'b0, 1'b0, '0, '0, -1);

    // Inputs rewritten mid-LOAD
    run_block(rnd128(), rnd128(), rnd128(), 5, 0, 4, 1'b0, 1'b0, '0, '0, -1);

    // Alternating dvld
    run_block(rnd128(), rnd128(), rnd128(), 3, 1, -1, 1'b0, 1'b0, '0, '0, -1);

    // aes_start held high across two back-to-back blocks
    k0 = rnd128(); p0 = rnd128(); r0 = rnd128();
    k1 = rnd128(); p1 = rnd128(); r1 = rnd128();
    run_block(k0, p0, r0, 7, 0, -1, 1'b1, 1'b0, k1, p1, -1);
    @(negedge clk);
    run_block(k1, p1, r1, 2, 2, -1, 1'b0, 1'b1, '0, '0, -1);

    // Randomized blocks
    for (int n = 0; n < 6; n++)
      run_block(rnd128(), rnd128(), rnd128(), int'($urandom_range(1, 30)), 2, -1,
                1'b0, 1'b0, '0, '0, -1);

    // Reset mid-COLLECT after 7 bytes, then a clean block
    run_block(rnd128(), rnd128(), rnd128(), 4, 0, -1, 1'b0, 1'b0, '0, '0, 7);
    run_block(rnd128(), rnd128(), rnd128(), 6, 2, -1, 1'b0, 1'b0, '0, '0, -1);

    // Timeout on the TIMEOUT_CYCLES=8 instance: core never finishes
    @(negedge clk);
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    repeat (16) @(negedge clk);
    chk("to_ld_off", 128'(t_ld), 128'd0);
    chk("to_busy", 128'(t_busy), 128'd1);
    for (int c = 0; c < 8; c++) begin
      chk("to_err_early", 128'({t_err, t_done}), 128'd0);
      @(negedge clk);
    end
    chk("to_err_pulse", 128'(t_err), 128'd1);
    chk("to_busy_low", 128'(t_busy), 128'd0);
    chk("to_ct_unchanged", t_ct, 128'd0);
    @(negedge clk);
    chk("to_err_one_cycle", 128'({t_err, t_done, t_busy}), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
